// File: rtl/kgp_control_fsm.sv
// KGP-RISC multi-cycle control unit: owns the PC, decodes opcode/funccode
// and sequences fetch, decode, execute, memory and write-back.
module kgp_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [4:0]  opcode,
  input  logic [4:0]  funccode,
  input  logic [31:0] nextInstrAddr,
  output logic [31:0] instrAddr,
  output logic [2:0]  ALUResOp,
  output logic        ALUCin,
  output logic        ALUDir,
  output logic [1:0]  ALUSrc,
  output logic        ALUFrc,
  output logic        brLink,
  output logic        memToReg,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic [2:0]  branch,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_MEMWAIT, S_WB, S_HALT
  } state_e;

  localparam logic [15:0] ILAST = 16'(IMEM_LAT - 1);
  localparam logic [15:0] DLAST = 16'(DMEM_LAT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pc_q, ret_q;
  logic        ill_q, ill_d;

  logic [2:0] op_q, br_q;
  logic [1:0] src_q;
  logic       cin_q, dir_q, frc_q, brl_q;
  logic       lw_q, sw_q, rw_q;

  logic [2:0] d_op, d_br;
  logic [1:0] d_src;
  logic       d_cin, d_dir, d_frc, d_brl;
  logic       d_lw, d_sw, d_rw, d_bad, d_halt;

  always_comb begin
    d_op   = 3'b000;
    d_br   = 3'b000;
    d_src  = 2'b00;
    d_cin  = 1'b0;
    d_dir  = 1'b0;
    d_frc  = 1'b0;
    d_brl  = 1'b0;
    d_lw   = 1'b0;
    d_sw   = 1'b0;
    d_rw   = 1'b0;
    d_bad  = 1'b0;
    d_halt = 1'b0;
    case (opcode)
      5'b00000: begin
        d_rw = 1'b1;
        case (funccode)
          5'b00000: d_op = 3'b000;
          5'b00001: begin d_op = 3'b101; d_cin = 1'b1; end
          5'b00010: d_op = 3'b001;
          5'b00011: d_op = 3'b010;
          5'b00100: begin d_op = 3'b011; d_src = 2'b10; end
          5'b00101: begin
            d_op = 3'b011; d_dir = 1'b1; d_src = 2'b10;
          end
          5'b01000: begin
            d_op = 3'b100; d_dir = 1'b1; d_src = 2'b10;
          end
          5'b00110: d_op = 3'b011;
          5'b00111: begin d_op = 3'b011; d_dir = 1'b1; end
          5'b01001: begin d_op = 3'b100; d_dir = 1'b1; end
          default: begin d_bad = 1'b1; d_rw = 1'b0; end
        endcase
      end
      5'b00001: begin d_src = 2'b01; d_rw = 1'b1; end
      5'b00010: begin
        d_op = 3'b101; d_cin = 1'b1; d_src = 2'b01; d_rw = 1'b1;
      end
      5'b00011: begin
        d_frc = 1'b1; d_src = 2'b01; d_lw = 1'b1; d_rw = 1'b1;
      end
      5'b00100: begin d_frc = 1'b1; d_src = 2'b01; d_sw = 1'b1; end
      5'b00101: d_br = 3'b001;
      5'b00110: begin d_br = 3'b001; d_brl = 1'b1; d_rw = 1'b1; end
      5'b00111: d_br = 3'b110;
      5'b01000: d_br = 3'b111;
      5'b01001: d_br = 3'b010;
      5'b01010: d_br = 3'b011;
      5'b01011: d_br = 3'b100;
      5'b01100: d_br = 3'b101;
      5'b11111: d_halt = 1'b1;
      default:  d_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == ILAST) state_d = S_DECODE;
        else cnt_d = cnt_q + 16'd1;
      end
      S_DECODE: begin
        if (d_bad) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else if (d_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (lw_q | sw_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (lw_q) begin
          state_d = S_MEMWAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEMWAIT: begin
        if (cnt_q == DLAST) state_d = S_WB;
        else cnt_d = cnt_q + 16'd1;
      end
      S_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
        cnt_d   = '0;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      if (state_q == S_WB) begin
        pc_q  <= nextInstrAddr;
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  // Decoded controls are captured once and held until write-back ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= '0;
      br_q  <= '0;
      src_q <= '0;
      cin_q <= 1'b0;
      dir_q <= 1'b0;
      frc_q <= 1'b0;
      brl_q <= 1'b0;
      lw_q  <= 1'b0;
      sw_q  <= 1'b0;
      rw_q  <= 1'b0;
    end else if (state_q == S_DECODE) begin
      op_q  <= d_op;
      br_q  <= d_br;
      src_q <= d_src;
      cin_q <= d_cin;
      dir_q <= d_dir;
      frc_q <= d_frc;
      brl_q <= d_brl;
      lw_q  <= d_lw;
      sw_q  <= d_sw;
      rw_q  <= d_rw;
    end
  end

  logic active;
  assign active = (state_q == S_EXEC) || (state_q == S_MEM) ||
                  (state_q == S_MEMWAIT) || (state_q == S_WB);

  assign instrAddr = pc_q;
  assign retired   = ret_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = ill_q;
  assign ALUResOp  = active ? op_q : 3'b000;
  assign branch    = active ? br_q : 3'b000;
  assign ALUSrc    = active ? src_q : 2'b00;
  assign ALUCin    = active & cin_q;
  assign ALUDir    = active & dir_q;
  assign ALUFrc    = active & frc_q;
  assign brLink    = active & brl_q;
  assign memToReg  = active & lw_q;
  assign memRead   = ((state_q == S_MEM) & lw_q) |
                     (state_q == S_MEMWAIT);
  assign memWrite  = (state_q == S_MEM) & sw_q;
  assign regWrite  = (state_q == S_WB) & rw_q;

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Directed bench for kgp_control_fsm: instruction sequences with
// hand-computed cycle-by-cycle expectations.
module tb_kgp_control_fsm;

  logic        clk, rst, run;
  logic [4:0]  opcode, funccode;
  logic [31:0] nextInstrAddr, instrAddr, retired;
  logic [2:0]  ALUResOp, branch;
  logic [1:0]  ALUSrc;
  logic        ALUCin, ALUDir, ALUFrc, brLink, memToReg;
  logic        memRead, memWrite, regWrite, halted, illegal;

  int nvec = 0;
  int nerr = 0;
  int nmr, nmw, nrw, wcyc;

  kgp_control_fsm dut (
    .clk(clk), .rst(rst), .run(run),
    .opcode(opcode), .funccode(funccode),
    .nextInstrAddr(nextInstrAddr), .instrAddr(instrAddr),
    .ALUResOp(ALUResOp), .ALUCin(ALUCin), .ALUDir(ALUDir),
    .ALUSrc(ALUSrc), .ALUFrc(ALUFrc), .brLink(brLink),
    .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .branch(branch), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] ctl();
    return 32'({ALUResOp, ALUCin, ALUDir, ALUSrc, ALUFrc, brLink,
                memToReg, memRead, memWrite, regWrite, branch});
  endfunction

  initial begin
    rst = 1'b1; run = 1'b1;
    opcode = 5'd0; funccode = 5'd0; nextInstrAddr = 32'd1;
    #1 rst = 1'b0;
    #1;
    chk("rst_pc", instrAddr, 32'd0);
    chk("rst_ret", retired, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_ctl", ctl(), 32'd0);
    @(negedge clk) rst = 1'b1;

    // add
    cyc(1);
    chk("add_fetch_rw", {31'd0, regWrite}, 32'd0);
    cyc(1);
    chk("add_dec_ctl", ctl(), 32'd0);
    cyc(2);
    chk("add_wb_rw", {31'd0, regWrite}, 32'd1);
    chk("add_wb_op", {29'd0, ALUResOp}, 32'd0);
    chk("add_wb_src", {30'd0, ALUSrc}, 32'd0);
    cyc(1);
    chk("add_pc", instrAddr, 32'd1);
    chk("add_ret", retired, 32'd1);
    chk("add_next_rw", {31'd0, regWrite}, 32'd0);

    // xor
    funccode = 5'b00011; nextInstrAddr = 32'd2;
    cyc(3);
    chk("xor_op", {29'd0, ALUResOp}, 32'd2);
    chk("xor_rw", {31'd0, regWrite}, 32'd1);
    cyc(1);
    chk("xor_pc", instrAddr, 32'd2);

    // shra
    funccode = 5'b01000; nextInstrAddr = 32'd3;
    cyc(3);
    chk("shra_op", {29'd0, ALUResOp}, 32'd4);
    chk("shra_src", {30'd0, ALUSrc}, 32'd2);
    chk("shra_dir", {31'd0, ALUDir}, 32'd1);
    cyc(1);
    chk("shra_ret", retired, 32'd3);

    // lw
    opcode = 5'b00011; funccode = 5'd0; nextInstrAddr = 32'd4;
    nmr = 0; nmw = 0;
    for (int c = 2; c <= 6; c++) begin
      cyc(1);
      nmr += int'(memRead);
      nmw += int'(memWrite);
      if (c == 3) chk("lw_frc", {31'd0, ALUFrc}, 32'd1);
      if (c == 6) begin
        chk("lw_m2r", {31'd0, memToReg}, 32'd1);
        chk("lw_rw", {31'd0, regWrite}, 32'd1);
        chk("lw_ret_wb", retired, 32'd3);
      end
    end
    chk("lw_nmr", nmr, 32'd2);
    chk("lw_nmw", nmw, 32'd0);
    cyc(1);
    chk("lw_ret", retired, 32'd4);
    chk("lw_pc", instrAddr, 32'd4);

    // sw
    opcode = 5'b00100; nextInstrAddr = 32'd5;
    nmw = 0; nrw = 0; wcyc = 0;
    for (int c = 2; c <= 5; c++) begin
      cyc(1);
      if (memWrite) begin nmw++; wcyc = c; end
      nrw += int'(regWrite);
    end
    chk("sw_nmw", nmw, 32'd1);
    chk("sw_wcyc", wcyc, 32'd4);
    chk("sw_nrw", nrw, 32'd0);
    cyc(1);
    chk("sw_ret", retired, 32'd5);
    chk("sw_pc", instrAddr, 32'd5);

    // bl
    opcode = 5'b00110; nextInstrAddr = 32'h40;
    cyc(3);
    chk("bl_br", {29'd0, branch}, 32'd1);
    chk("bl_brl", {31'd0, brLink}, 32'd1);
    chk("bl_rw", {31'd0, regWrite}, 32'd1);
    cyc(1);
    chk("bl_pc", instrAddr, 32'h40);
    chk("bl_fetch_brl", {31'd0, brLink}, 32'd0);

    // bz, with run dropped during EXEC
    opcode = 5'b01011; nextInstrAddr = 32'h41;
    cyc(2);
    run = 1'b0;
    chk("bz_exec_br", {29'd0, branch}, 32'd4);
    cyc(1);
    chk("bz_wb_rw", {31'd0, regWrite}, 32'd0);
    chk("bz_wb_br", {29'd0, branch}, 32'd4);
    cyc(1);
    chk("idle_pc", instrAddr, 32'h41);
    chk("idle_ret", retired, 32'd7);
    cyc(3);
    chk("idle_stay_ret", retired, 32'd7);
    chk("idle_ctl", ctl(), 32'd0);

    // sw interrupted by reset in MEM
    opcode = 5'b00100; nextInstrAddr = 32'h99; run = 1'b1;
    cyc(4);
    chk("swr_mem_mw", {31'd0, memWrite}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("swr_mw", {31'd0, memWrite}, 32'd0);
    chk("swr_pc", instrAddr, 32'd0);
    chk("swr_ret", retired, 32'd0);

    // halt opcode
    opcode = 5'b11111;
    @(negedge clk) rst = 1'b1;
    cyc(2);
    chk("halt_dec", {31'd0, halted}, 32'd0);
    cyc(1);
    chk("halt_h", {31'd0, halted}, 32'd1);
    chk("halt_ill", {31'd0, illegal}, 32'd0);
    opcode = 5'd0;
    cyc(3);
    chk("halt_stay", {31'd0, halted}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("halt_rst", {31'd0, halted}, 32'd0);

    // add to PC 5, then undefined opcode 10101
    opcode = 5'd0; funccode = 5'd0; nextInstrAddr = 32'd5;
    @(negedge clk) rst = 1'b1;
    cyc(5);
    chk("ill_pre_pc", instrAddr, 32'd5);
    opcode = 5'b10101; nextInstrAddr = 32'h77;
    cyc(2);
    chk("ill_h", {31'd0, halted}, 32'd1);
    chk("ill_ill", {31'd0, illegal}, 32'd1);
    opcode = 5'd0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("ill_frz_pc", instrAddr, 32'd5);
      chk("ill_frz_ctl", ctl(), 32'd0);
      chk("ill_frz_h", {31'd0, halted}, 32'd1);
    end
    chk("ill_ret", retired, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("ill_rst", {31'd0, illegal}, 32'd0);

    // undefined funccode under R-type
    funccode = 5'b01010;
    @(negedge clk) rst = 1'b1;
    cyc(3);
    chk("fn_h", {31'd0, halted}, 32'd1);
    chk("fn_ill", {31'd0, illegal}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
